// File: rtl/adas_pkg.sv
// Shared types and parameter checks for the ADAS brake controller family.
// Holds the FSM state encoding used by the top and its debug port.
package adas_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_CONFIRM = 3'd1,
        ST_BRAKE   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_FAULT   = 3'd4
    } adas_state_t;

    function automatic bit params_legal(
        input int n,
        input int th,
        input int c,
        input int h,
        input int f,
        input int ew
    );
        return (n >= 2) && (th >= 1) && (th <= n) &&
               (c >= 1) && (h >= 1) && (f >= 1) && (ew >= 1);
    endfunction

endpackage

// File: rtl/adas_vote.sv
// K-of-N obstacle vote: popcount of the sensor vector against a threshold.
// Purely combinational so it can be replicated per zone.
module adas_vote
    import adas_pkg::*;
#(
    parameter int SENSOR_COUNT   = 3,
    parameter int VOTE_THRESHOLD = 2
) (
    input  logic [SENSOR_COUNT-1:0] sensor,
    output logic                    vote
);

    localparam int CW = $clog2(SENSOR_COUNT + 1);

    logic [CW-1:0] votes;

    always_comb begin
        votes = '0;
        for (int i = 0; i < SENSOR_COUNT; i++) begin
            votes = votes + CW'(sensor[i]);
        end
        vote = (votes >= CW'(VOTE_THRESHOLD));
    end

endmodule

// File: rtl/adas_brake_controller.sv
// Clocked ADAS brake decision: voted threat, confirm delay, brake hold,
// latched fault mode and a saturating brake event counter.
module adas_brake_controller
    import adas_pkg::*;
#(
    parameter int SENSOR_COUNT       = 3,
    parameter int VOTE_THRESHOLD     = 2,
    parameter int CONFIRM_CYCLES     = 4,
    parameter int HOLD_CYCLES        = 8,
    parameter int FAULT_CLEAR_CYCLES = 16,
    parameter int EVENT_WIDTH        = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    driver_break,
    input  logic [SENSOR_COUNT-1:0] sensor,
    input  logic                    adas_error,
    output logic                    vehicle_break,
    output logic                    adas_brake,
    output logic                    fault,
    output logic [STATE_W-1:0]      state,
    output logic [EVENT_WIDTH-1:0]  brake_events
);

    if (!params_legal(SENSOR_COUNT, VOTE_THRESHOLD, CONFIRM_CYCLES,
                      HOLD_CYCLES, FAULT_CLEAR_CYCLES, EVENT_WIDTH))
    begin : g_param_err
        $error("adas_brake_controller: illegal parameters");
    end

    localparam int CCW = $clog2(CONFIRM_CYCLES + 1);
    localparam int HCW = $clog2(HOLD_CYCLES + 1);
    localparam int FCW = $clog2(FAULT_CLEAR_CYCLES + 1);

    adas_state_t            state_q, state_d;
    logic [CCW-1:0]         confirm_q, confirm_d;
    logic [HCW-1:0]         hold_q, hold_d;
    logic [FCW-1:0]         clear_q, clear_d;
    logic [EVENT_WIDTH-1:0] events_q, events_d;
    logic                   brake_q, brake_d;
    logic                   fault_q, fault_d;
    logic                   event_hit;
    logic                   vote;
    logic                   qualify;

    adas_vote #(
        .SENSOR_COUNT   (SENSOR_COUNT),
        .VOTE_THRESHOLD (VOTE_THRESHOLD)
    ) u_vote (
        .sensor (sensor),
        .vote   (vote)
    );

    assign qualify = vote & ~adas_error;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            confirm_q <= '0;
            hold_q    <= '0;
            clear_q   <= '0;
            events_q  <= '0;
            brake_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            confirm_q <= confirm_d;
            hold_q    <= hold_d;
            clear_q   <= clear_d;
            events_q  <= events_d;
            brake_q   <= brake_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        confirm_d = confirm_q;
        hold_d    = hold_q;
        clear_d   = clear_q;
        event_hit = 1'b0;
        if (adas_error) begin
            state_d   = ST_FAULT;
            confirm_d = '0;
            hold_d    = '0;
            clear_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (qualify) begin
                        if (CONFIRM_CYCLES == 1) begin
                            state_d   = ST_BRAKE;
                            event_hit = 1'b1;
                        end else begin
                            state_d   = ST_CONFIRM;
                            confirm_d = CCW'(1);
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (!qualify) begin
                        state_d   = ST_IDLE;
                        confirm_d = '0;
                    end else if (confirm_q == CCW'(CONFIRM_CYCLES - 1)) begin
                        state_d   = ST_BRAKE;
                        confirm_d = '0;
                        event_hit = 1'b1;
                    end else begin
                        confirm_d = confirm_q + CCW'(1);
                    end
                end
                ST_BRAKE: begin
                    if (!qualify) begin
                        state_d = ST_HOLD;
                        hold_d  = HCW'(HOLD_CYCLES - 1);
                    end
                end
                ST_HOLD: begin
                    // A returning threat resumes the same brake episode.
                    if (qualify) begin
                        state_d = ST_BRAKE;
                        hold_d  = '0;
                    end else if (hold_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        hold_d = hold_q - HCW'(1);
                    end
                end
                ST_FAULT: begin
                    if (clear_q == FCW'(FAULT_CLEAR_CYCLES - 1)) begin
                        state_d = ST_IDLE;
                        clear_d = '0;
                    end else begin
                        clear_d = clear_q + FCW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        brake_d  = (state_d == ST_BRAKE) || (state_d == ST_HOLD);
        fault_d  = (state_d == ST_FAULT);
        events_d = events_q;
        if (event_hit && (events_q != '1)) begin
            events_d = events_q + EVENT_WIDTH'(1);
        end
    end

    assign adas_brake    = brake_q;
    assign fault         = fault_q;
    assign state         = state_q;
    assign brake_events  = events_q;
    assign vehicle_break = driver_break | brake_q;

endmodule
